// File: rtl/nn_index_sequencer.sv
// Nearest-neighbour index generator for the pitch-shift resampler: streams
// floor/round(k * shift) for k = 0..count-1 using an accumulator, no multiplier.
module nn_index_sequencer #(
  parameter int FRAC_BITS = 20,
  parameter int SHIFT_W   = 32,
  parameter int IDX_W     = 9,
  parameter int OUT_W     = 11,
  parameter int ROUND     = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [IDX_W-1:0]   count,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_index,
  output logic [OUT_W-1:0]   shifted_index,
  output logic               ovr,
  output logic               done
);

  // IDX_W + SHIFT_W bits hold k*shift for every legal k and shift.
  localparam int ACC_W = IDX_W + SHIFT_W;
  localparam logic [ACC_W:0] RND_ADD =
    (ROUND != 0) ? ((ACC_W + 1)'(1) << (FRAC_BITS - 1)) : '0;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state;
  logic [SHIFT_W-1:0] shift_l;
  logic [IDX_W-1:0]   count_l;
  logic [ACC_W-1:0]   acc;

  logic [ACC_W-1:0]   acc_nxt;
  logic [ACC_W:0]     rsum;
  logic [ACC_W:0]     r;
  logic               sat;
  logic [OUT_W-1:0]   sat_index;
  logic               hs;
  logic               last;

  // Result for the word after the current one, derived from the next acc value.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    acc_nxt   = acc + ACC_W'(shift_l);
    rsum      = {1'b0, acc_nxt} + RND_ADD;
    r         = rsum >> FRAC_BITS;
    sat       = |(r >> OUT_W);
    sat_index = sat ? '1 : r[OUT_W-1:0];
    hs        = out_valid && out_ready;
    last      = (out_index == count_l - IDX_W'(1));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      shift_l       <= '0;
      count_l       <= '0;
      acc           <= '0;
      busy          <= 1'b0;
      out_valid     <= 1'b0;
      out_index     <= '0;
      shifted_index <= '0;
      ovr           <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shift_l       <= shift;
            count_l       <= count;
            acc           <= '0;
            busy          <= 1'b1;
            out_index     <= '0;
            shifted_index <= '0;
            ovr           <= 1'b0;
            if (count == '0) begin
              state     <= FIN;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              state     <= RUN;
              out_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs) begin
            acc <= acc_nxt;
            if (last) begin
              state     <= FIN;
              out_valid <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
            end else begin
              out_index     <= out_index + IDX_W'(1);
              shifted_index <= sat_index;
              ovr           <= sat;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
